c17_bist_ctrl: RTL and testbench
================================

// Module: c17_bist_ctrl
// PURPOSE
// Built-in self-test driver for the c17 NAND benchmark and its bit-level pipelined variants.
// A 5-bit LFSR generates patterns on the CUT inputs, and an 8-bit MISR compacts the CUT
// outputs. It sits at the opposite end of the c17 interface: it drives N1..N7 and samples
// N22/N23. A start/busy/done handshake reports a pass/fail result against a golden signature.
// PARAMETERS
// N_PATTERNS  31       patterns applied per run, 1..255
// CUT_LAT     0        CUT latency in clocks (0 = combinational c17; k = k-stage pipelined c17)
// LFSR_SEED   5'h01    LFSR load value; 0 is illegal and is replaced by 5'h01
// MISR_SEED   8'h00    MISR load value at start
// PORTS
// clk         in   1  rising-edge clock
// rst_n       in   1  asynchronous active-low reset
// start       in   1  one-cycle run request; sampled in IDLE/DONE only
// golden_sig  in   8  expected signature; compared when the run ends
// cut_out     in   2  {N22,N23} from the CUT
// cut_in      out  5  {N1,N2,N3,N6,N7} to the CUT, registered
// busy        out  1  high in RUN and FLUSH
// done        out  1  high in DONE
// pass        out  1  valid while done=1: signature==golden_sig
// signature   out  8  current MISR contents
// BEHAVIOUR
// - Reset (async, any state): FSM=IDLE; cut_in=0; busy=0; done=0; pass=0; signature=MISR_SEED;
//   LFSR=LFSR_SEED; pattern count=0; valid pipe cleared. A run in progress is aborted, with no done.
// - LFSR: next = {q[3:0], q[4]^q[2]}, which is x^5+x^3+1 (maximal, period 31).
// - MISR: m_next = {m[6:0],1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {6'b0, cut_out}.
// - FSM IDLE: if start=1, load LFSR/MISR seeds, count=0, go to RUN. cut_in holds 0.
// - FSM RUN: each clock, cut_in <= LFSR, LFSR advances, count++, and a valid bit enters a
//   CUT_LAT-deep pipe. After the N_PATTERNS-th pattern, go to FLUSH if CUT_LAT>0, else to DONE.
//   The first pattern appears on cut_in the cycle after start is sampled.
// - Compaction: the MISR updates on an edge only when the valid bit delayed by CUT_LAT is high.
//   With CUT_LAT=0, cut_out is sampled at the edge that ends the cycle in which the pattern is
//   driven.
// - FSM FLUSH: cut_in=0. Stay for exactly CUT_LAT cycles, then go to DONE.
// - FSM DONE: done=1; pass is registered on DONE entry from (final MISR==golden_sig).
//   Hold state until start=1, which restarts directly into RUN with a fresh seed load and
//   clears done/pass.
// - busy is high for exactly N_PATTERNS+CUT_LAT cycles. done rises N_PATTERNS+CUT_LAT+1
//   edges after the start sample.
// - start is ignored while busy=1. start and reset together: reset wins.
// - count is 8-bit; it never wraps because N_PATTERNS<=255. With N_PATTERNS>31 the LFSR
//   repeats from the seed.
// TESTING
// - Reset mid-RUN, at pattern 5 -> next cycle: busy=0, done=0, cut_in=0, signature=8'h00;
//   no done pulse follows.
// - N_PATTERNS=4, CUT_LAT=0, seed 01: pulse start -> cut_in sequence 01,02,04,09 on
//   consecutive cycles, then 00.
// - N_PATTERNS=3, CUT_LAT=0, real c17 CUT, golden=8'h04 -> MISR 01,02,04; done=1, pass=1
//   on the 4th edge after start.
// - Same run with golden=8'h05 -> done=1, pass=0, signature=8'h04.
// - CUT_LAT=2, 2-stage pipelined c17, N_PATTERNS=3, golden=8'h04 -> busy high 5 cycles,
//   pass=1.
// - N_PATTERNS=31 -> all 31 nonzero cut_in values seen once; start pulse during busy
//   ignored; start in DONE reruns with identical signature.

Source files
------------

// File: rtl/c17_bist_ctrl.sv
// BIST driver for the c17 benchmark: a 5-bit LFSR feeds the CUT inputs and an 8-bit MISR
// compacts the CUT outputs, with a start/busy/done handshake and a golden-signature verdict.
module c17_bist_ctrl #(
  parameter int unsigned N_PATTERNS = 31,
  parameter int unsigned CUT_LAT    = 0,
  parameter logic [4:0]  LFSR_SEED  = 5'h01,
  parameter logic [7:0]  MISR_SEED  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] golden_sig,
  input  logic [1:0] cut_out,
  output logic [4:0] cut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [4:0] SeedEff   = (LFSR_SEED == 5'h00) ? 5'h01 : LFSR_SEED;
  localparam logic [7:0] NPat      = 8'(N_PATTERNS);
  localparam logic [7:0] FlushLast = 8'((CUT_LAT == 0) ? 0 : CUT_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e         state_q;
  logic [4:0]     lfsr_q;
  logic [7:0]     count_q;
  logic [7:0]     flush_q;
  logic [7:0]     misr_q;
  logic [7:0]     misr_d;
  logic [CUT_LAT:0] vld_q;
  logic [4:0]     cut_in_q;
  logic           busy_q;
  logic           done_q;
  logic           pass_q;

  function automatic logic [4:0] lfsr_next(input logic [4:0] q);
    return {q[3:0], q[4] ^ q[2]};
  endfunction

  // Compaction is enabled by the valid bit that has travelled as far as the CUT's latency.
  always_comb begin
    misr_d = misr_q;
    if (vld_q[CUT_LAT]) begin
      misr_d = {misr_q[6:0], 1'b0} ^ (misr_q[7] ? 8'h1D : 8'h00) ^ {6'b0, cut_out};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lfsr_q   <= SeedEff;
      count_q  <= '0;
      flush_q  <= '0;
      misr_q   <= MISR_SEED;
      vld_q    <= '0;
      cut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      misr_q   <= misr_d;
      vld_q[0] <= 1'b0;
      for (int i = 1; i <= int'(CUT_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q  <= StRun;
            cut_in_q <= SeedEff;
            lfsr_q   <= lfsr_next(SeedEff);
            count_q  <= 8'd1;
            vld_q[0] <= 1'b1;
            misr_q   <= MISR_SEED;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        StRun: begin
          if (count_q == NPat) begin
            cut_in_q <= '0;
            if (CUT_LAT == 0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (misr_d == golden_sig);
            end else begin
              state_q <= StFlush;
              flush_q <= '0;
            end
          end else begin
            cut_in_q <= lfsr_q;
            lfsr_q   <= lfsr_next(lfsr_q);
            count_q  <= count_q + 8'd1;
            vld_q[0] <= 1'b1;
          end
        end
        StFlush: begin
          if (flush_q == FlushLast) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (misr_d == golden_sig);
          end else begin
            flush_q <= flush_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cut_in    = cut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Bench for c17_bist_ctrl: four configurations driving a behavioural c17 (optionally pipelined),
// each run compared against a sequence-level model of patterns, timing and signature.
module tb_c17_bist_ctrl;

  localparam int NDUT = 4;
  localparam int         NP  [NDUT] = '{4, 3, 3, 31};
  localparam int         LAT [NDUT] = '{0, 0, 2, 1};
  localparam logic [4:0] LS  [NDUT] = '{5'h01, 5'h01, 5'h00, 5'h13};
  localparam logic [7:0] MS  [NDUT] = '{8'h00, 8'h00, 8'h00, 8'hA5};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NDUT-1:0] start;
  logic [7:0]      golden  [NDUT];
  logic [1:0]      cut_out [NDUT];
  logic [4:0]      cut_in  [NDUT];
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] done;
  logic [NDUT-1:0] pass;
  logic [7:0]      sig     [NDUT];
  logic [1:0]      cpipe   [NDUT][2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  c17_bist_ctrl #(.N_PATTERNS(4), .CUT_LAT(0), .LFSR_SEED(5'h01), .MISR_SEED(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .golden_sig(golden[0]), .cut_out(cut_out[0]),
    .cut_in(cut_in[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0]));
  c17_bist_ctrl #(.N_PATTERNS(3), .CUT_LAT(0), .LFSR_SEED(5'h01), .MISR_SEED(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .golden_sig(golden[1]), .cut_out(cut_out[1]),
    .cut_in(cut_in[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1]));
  c17_bist_ctrl #(.N_PATTERNS(3), .CUT_LAT(2), .LFSR_SEED(5'h00), .MISR_SEED(8'h00)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .golden_sig(golden[2]), .cut_out(cut_out[2]),
    .cut_in(cut_in[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2]));
  c17_bist_ctrl #(.N_PATTERNS(31), .CUT_LAT(1), .LFSR_SEED(5'h13), .MISR_SEED(8'hA5)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .golden_sig(golden[3]), .cut_out(cut_out[3]),
    .cut_in(cut_in[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]), .signature(sig[3]));

  function automatic logic [1:0] c17(input logic [4:0] x);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n1, n2, n3, n6, n7} = x;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  // Pipelined CUT variants: c17 followed by LAT output register stages.
  always_ff @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      cpipe[d][0] <= c17(cut_in[d]);
      cpipe[d][1] <= cpipe[d][0];
    end
  end

  always_comb begin
    for (int d = 0; d < NDUT; d++) begin
      cut_out[d] = c17(cut_in[d]);
      if (LAT[d] == 1) cut_out[d] = cpipe[d][0];
      if (LAT[d] == 2) cut_out[d] = cpipe[d][1];
    end
  end

  function automatic logic [4:0] lfsr_step(input logic [4:0] q);
    return {q[3:0], q[4] ^ q[2]};
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [1:0] o);
    return {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {6'b0, o};
  endfunction

  function automatic logic [4:0] seed_of(input int d);
    return (LS[d] == 5'h00) ? 5'h01 : LS[d];
  endfunction

  // Signature of a whole run: fold the CUT responses of the pattern sequence into the MISR.
  function automatic logic [7:0] exp_sig(input int d);
    logic [4:0] p;
    logic [7:0] m;
    p = seed_of(d);
    m = MS[d];
    for (int j = 0; j < NP[d]; j++) begin
      m = misr_step(m, c17(p));
      p = lfsr_step(p);
    end
    return m;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_run(input int d, input logic [7:0] gold, input bit poke);
    logic [4:0]  p;
    logic [7:0]  m;
    logic [31:0] seen;
    int n, l, hold;
    n = NP[d];
    l = LAT[d];
    p = seed_of(d);
    m = exp_sig(d);
    seen = '0;
    golden[d] = gold;
    @(negedge clk);
    start[d] = 1'b1;
    for (int k = 1; k <= n + l + 1; k++) begin
      @(negedge clk);
      start[d] = poke && (k == 2);  // must be ignored while busy
      if (k <= n) begin
        check_eq($sformatf("cut_in d%0d k%0d", d, k), cut_in[d], p);
        seen[p] = 1'b1;
        p = lfsr_step(p);
      end else begin
        check_eq($sformatf("cut_in_idle d%0d k%0d", d, k), cut_in[d], 0);
      end
      check_eq($sformatf("busy d%0d k%0d", d, k), busy[d], k <= n + l);
      check_eq($sformatf("done d%0d k%0d", d, k), done[d], k == n + l + 1);
    end
    check_eq($sformatf("unique_patterns d%0d", d), $countones(seen), n);
    hold = $urandom_range(1, 4);
    for (int h = 0; h < hold; h++) begin
      check_eq($sformatf("sig d%0d", d), sig[d], m);
      check_eq($sformatf("pass d%0d", d), pass[d], m == gold);
      check_eq($sformatf("done_hold d%0d", d), done[d], 1);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [4:0] p;
    int d;
    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < NDUT; i++) golden[i] = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("rst_cut_in d%0d", i), cut_in[i], 0);
      check_eq($sformatf("rst_flags d%0d", i), {busy[i], done[i], pass[i]}, 0);
      check_eq($sformatf("rst_sig d%0d", i), sig[i], MS[i]);
    end
    rst_n = 1'b1;

    // Abort a long run at its fifth pattern.
    @(negedge clk);
    start[3] = 1'b1;
    p = seed_of(3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start[3] = 1'b0;
      if (k < 5) p = lfsr_step(p);
    end
    check_eq("abort_pattern5", cut_in[3], p);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_cut_in", cut_in[3], 0);
    check_eq("abort_flags", {busy[3], done[3], pass[3]}, 0);
    check_eq("abort_sig", sig[3], MS[3]);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check_eq("abort_no_done", {busy[3], done[3]}, 0);
    end

    do_run(0, 8'h3C, 1'b0);
    do_run(1, 8'h04, 1'b0);
    check_eq("c17_n3_sig", sig[1], 8'h04);
    check_eq("c17_n3_pass", pass[1], 1);
    do_run(1, 8'h05, 1'b0);
    check_eq("c17_n3_fail", {pass[1], sig[1]}, {1'b0, 8'h04});
    do_run(2, 8'h04, 1'b1);
    check_eq("c17_lat2_pass", pass[2], 1);
    do_run(3, exp_sig(3), 1'b1);
    do_run(3, exp_sig(3), 1'b0);

    for (int r = 0; r < 16; r++) begin
      d = $urandom_range(0, NDUT - 1);
      do_run(d, ($urandom_range(0, 1) == 1) ? exp_sig(d) : 8'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
